// File: rtl/ppl_hazard_ctrl_if.sv
// ppl_hazard_ctrl_if
// Bundles the hazard-controller signals between the 5-stage pipeline datapath
// and the sequencing controller.
//   slave  : the controller side. It receives the ID/EX hazard info and mem_busy,
//            and drives the register enables/flushes, valids, counters and watchdog.
//   master : the datapath side, with the directions mirrored.
interface ppl_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4
);
  // Hazard information from the datapath
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_wen;
  logic                  ex_is_load;
  logic                  ex_branch_taken;
  logic                  mem_busy;

  // Pipeline register controls
  logic                  pc_en;
  logic                  ifid_en;
  logic                  idex_en;
  logic                  exmem_en;
  logic                  memwb_en;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  memwb_flush;

  // Status
  logic [3:0]            stage_valid;   // {v_wb, v_mem, v_ex, v_id}
  logic [15:0]           stall_cnt;
  logic [15:0]           flush_cnt;
  logic                  stall_timeout;

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_rd, ex_wen, ex_is_load, ex_branch_taken, mem_busy,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush,
           stage_valid, stall_cnt, flush_cnt, stall_timeout
  );

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_rd, ex_wen, ex_is_load, ex_branch_taken, mem_busy,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush,
           stage_valid, stall_cnt, flush_cnt, stall_timeout
  );
endinterface

// File: rtl/ppl_hazard_ctrl.sv
// ppl_hazard_ctrl
// Sequencing controller for the IF/ID/EX/MEM/WB pipeline. Each cycle it picks one
// of four modes, with priority busy > branch > load-use > normal. It drives the
// PC and inter-stage register enables/flushes combinationally, tracks a valid bit
// per stage, counts stall and flush cycles (saturating), and runs a sticky
// watchdog on consecutive mem_busy cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   hz    : ppl_hazard_ctrl_if.slave (hazard inputs, register controls, status)
module ppl_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int MAX_STALL  = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  ppl_hazard_ctrl_if.slave   hz
);

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_LU     = 2'd1;
  localparam logic [1:0] MODE_BR     = 2'd2;
  localparam logic [1:0] MODE_BUSY   = 2'd3;

  // busy_run value seen on the MAX_STALL-th consecutive busy cycle
  localparam logic [15:0] TRIP_AT = 16'(MAX_STALL - 1);

  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  v_id, v_ex, v_mem, v_wb;
  logic                  br, lu;
  logic [1:0]            mode;
  logic [15:0]           stall_cnt, flush_cnt, busy_run;
  logic                  stall_timeout;

  assign rs1 = hz.id_rs1;
  assign rs2 = hz.id_rs2;
  assign rd  = hz.ex_rd;

  // Bubbles in EX or ID never raise a hazard.
  assign br = hz.ex_branch_taken & v_ex;
  assign lu = v_id & v_ex & hz.ex_is_load & hz.ex_wen &
              ((hz.id_rs1_used & (rs1 == rd)) | (hz.id_rs2_used & (rs2 == rd)));

  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    mode = MODE_NORMAL;
    if (hz.mem_busy) mode = MODE_BUSY;
    else if (br)     mode = MODE_BR;
    else if (lu)     mode = MODE_LU;
  end

  always_comb begin
    hz.pc_en       = 1'b1;
    hz.ifid_en     = 1'b1;
    hz.idex_en     = 1'b1;
    hz.exmem_en    = 1'b1;
    hz.memwb_en    = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.memwb_flush = 1'b0;
    if (!rst_n) begin
      // Hold everything and load bubbles while reset is asserted.
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      hz.idex_en     = 1'b0;
      hz.exmem_en    = 1'b0;
      hz.memwb_en    = 1'b0;
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.memwb_flush = 1'b1;
    end else begin
      case (mode)
        MODE_BUSY: begin
          // Freeze upstream; WB drains a bubble so a retired result is not rewritten.
          hz.pc_en       = 1'b0;
          hz.ifid_en     = 1'b0;
          hz.idex_en     = 1'b0;
          hz.exmem_en    = 1'b0;
          hz.memwb_flush = 1'b1;
        end
        MODE_BR: begin
          hz.ifid_flush = 1'b1;
          hz.idex_flush = 1'b1;
        end
        MODE_LU: begin
          // Hold IF/ID and insert one bubble into EX; the load advances to MEM.
          hz.pc_en      = 1'b0;
          hz.ifid_en    = 1'b0;
          hz.idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_id          <= 1'b0;
      v_ex          <= 1'b0;
      v_mem         <= 1'b0;
      v_wb          <= 1'b0;
      stall_cnt     <= 16'd0;
      flush_cnt     <= 16'd0;
      busy_run      <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      case (mode)
        MODE_BUSY: begin
          v_wb <= 1'b0;
        end
        MODE_BR: begin
          v_id  <= 1'b0;
          v_ex  <= 1'b0;
          v_mem <= v_ex;
          v_wb  <= v_mem;
        end
        MODE_LU: begin
          v_ex  <= 1'b0;
          v_mem <= v_ex;
          v_wb  <= v_mem;
        end
        default: begin
          v_id  <= 1'b1;
          v_ex  <= v_id;
          v_mem <= v_ex;
          v_wb  <= v_mem;
        end
      endcase

      if ((mode == MODE_BUSY || mode == MODE_LU) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (mode == MODE_BR && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;

      if (hz.mem_busy) begin
        if (busy_run != 16'hFFFF) busy_run <= busy_run + 16'd1;
        if (busy_run == TRIP_AT)  stall_timeout <= 1'b1;
      end else begin
        busy_run <= 16'd0;
      end
    end
  end

  assign hz.stage_valid   = {v_wb, v_mem, v_ex, v_id};
  assign hz.stall_cnt     = stall_cnt;
  assign hz.flush_cnt     = flush_cnt;
  assign hz.stall_timeout = stall_timeout;

endmodule

// File: doc/ppl_hazard_ctrl.md
# ppl_hazard_ctrl

Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB). It drives the enable and flush controls of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It resolves memory-busy freezes, taken-branch flushes and load-use bubbles, and tracks a valid bit per stage. It also keeps stall/flush performance counters and a memory-stall watchdog.

## Interface
- `REG_ADDR_W`, default 4: register-specifier width.
- `MAX_STALL`, default 255: consecutive `mem_busy` cycles that trip the watchdog (range 1..65535).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `id_rs1`, `id_rs2` input REG_ADDR_W: source specifiers of the ID-stage instruction.
- `id_rs1_used`, `id_rs2_used` input 1: corresponding source is actually read.
- `ex_rd` input REG_ADDR_W: destination of the EX-stage instruction.
- `ex_wen`, `ex_is_load` input 1: EX instruction writes `ex_rd` / is a load.
- `ex_branch_taken` input 1: EX instruction is a resolved taken branch.
- `mem_busy` input 1: data memory cannot complete this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` output 1: register load enables.
- `ifid_flush`, `idex_flush`, `memwb_flush` output 1: load a bubble (all-zero) instead of D. Flush overrides enable at the register.
- `stage_valid` output 4: {v_wb, v_mem, v_ex, v_id}.
- `stall_cnt` output 16: cycles with `pc_en`=0. Saturating.
- `flush_cnt` output 16: taken-branch flush events. Saturating.
- `stall_timeout` output 1: sticky watchdog flag.

## Operation
- Qualified events:
  - `busy` = `mem_busy`.
  - `br` = `ex_branch_taken` & v_ex.
  - `lu` = v_id & v_ex & `ex_is_load` & `ex_wen` & ((`id_rs1_used` & `id_rs1`==`ex_rd`) | (`id_rs2_used` & `id_rs2`==`ex_rd`)).
- Priority is `busy` > `br` > `lu` > normal. Exactly one mode is active per cycle.
- Control outputs are combinational from the current inputs and valid bits:
  - busy: `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=0, `memwb_en`=1, `memwb_flush`=1, other flushes 0.
  - br: all enables 1, `ifid_flush`=`idex_flush`=1, `memwb_flush`=0.
  - lu: `pc_en`=`ifid_en`=0, `idex_en`=`exmem_en`=`memwb_en`=1, `idex_flush`=1, other flushes 0.
  - normal: all enables 1, all flushes 0.
- Valid update on each clock edge while `rst_n`=1:
  - busy: v_id, v_ex, v_mem hold; v_wb<=0.
  - br: v_id<=0, v_ex<=0, v_mem<=v_ex, v_wb<=v_mem.
  - lu: v_id holds, v_ex<=0, v_mem<=v_ex, v_wb<=v_mem.
  - normal: v_id<=1, v_ex<=v_id, v_mem<=v_ex, v_wb<=v_mem.
- Forwarding from EX/MEM and MEM/WB is handled outside this block. Only load-use needs a bubble, and exactly one bubble per hazard.
- Counters:
  - `stall_cnt` +1 in every cycle with `pc_en`=0 (busy or lu).
  - `flush_cnt` +1 in every br cycle.
  - Both saturate at 16'hFFFF.
- Watchdog:
  - Internal 16-bit `busy_run` increments while `mem_busy`=1 and clears to 0 when `mem_busy`=0.
  - When `busy_run` reaches MAX_STALL-1 while `mem_busy`=1, `stall_timeout`<=1 on that edge, i.e. after MAX_STALL consecutive busy cycles.
  - `stall_timeout` stays 1 until reset.

## Timing
- Enables and flushes have zero latency: they are valid in the same cycle as the inputs. Valids and counters update at the next rising edge.
- Reset: while `rst_n`=0, `pc_en` and all `*_en`=0, all `*_flush`=1. At the edge, `stage_valid`=4'b0000, `stall_cnt`=`flush_cnt`=0, `busy_run`=0, `stall_timeout`=0.
- Reset mid-stall or mid-flush discards all state. First cycle after reset release is normal mode with no hazards, because the valid bits are 0.
- Pipeline fill: v_id=1 one cycle after release, stage_valid=4'b1111 after four normal cycles.
- A load-use hazard resolves in one cycle: the load moves to MEM and `lu` drops next cycle.
- br with simultaneous lu: br wins, the stalled ID instruction is flushed, and no stall is counted.
- busy with br or lu: the whole pipeline freezes. The br or lu remains pending and is acted on in the first non-busy cycle.
- Hazards are ignored when v_ex=0 or v_id=0 (bubbles never stall or flush).

## Test plan
- Reset then 4 normal cycles: `stage_valid` goes 0001, 0011, 0111, 1111. All enables 1, all flushes 0, counters 0.
- Load-use: v=1111, `ex_is_load`=`ex_wen`=1, `ex_rd`=3, `id_rs2`=3, `id_rs2_used`=1 for one cycle. Same cycle `pc_en`=`ifid_en`=0, `idex_flush`=1. Next cycle stage_valid=1101, `stall_cnt`=1. Repeat with `id_rs2_used`=0: no stall.
- Taken branch with v_ex=1 and a coincident load-use: `ifid_flush`=`idex_flush`=1, `pc_en`=1. Next cycle v_id=v_ex=0, `flush_cnt`=1, `stall_cnt` unchanged.
- `mem_busy` for 3 cycles with MAX_STALL=255: all upstream enables 0, `memwb_flush`=1, v_id/v_ex/v_mem held, v_wb=0, `stall_cnt`=3, `stall_timeout`=0.
- MAX_STALL=4 with `mem_busy` held 4 cycles: `stall_timeout`=1 after the 4th edge. It remains 1 after `mem_busy` drops and clears only on `rst_n`=0.
- Force `stall_cnt` to saturate (65536+ busy cycles): value holds at 16'hFFFF. Assert `rst_n`=0 mid-busy: all outputs return to reset values at the next edge.
